// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a first-word-fall-through byte FIFO
//
// Purpose: turns the asynchronous serial line into a byte stream with a
// ready/valid handshake toward the calculator core.
// Ports:
//   Clk        - system clock, rising edge
//   Reset      - asynchronous, active-high reset
//   UartRxWire - raw serial line, idles high, asynchronous to Clk
//   Data       - head-of-FIFO byte, meaningful while Valid is high
//   Valid      - FIFO not empty
//   Ready      - consumer takes Data this cycle
//   FrameError - one-cycle pulse, stop bit sampled low
//   Overflow   - one-cycle pulse, good byte dropped on a full FIFO
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       UartRxWire,
  output logic [7:0] Data,
  output logic       Valid,
  input  logic       Ready,
  output logic       FrameError,
  output logic       Overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state, state_next;
  logic            rx_meta, rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            cnt_clr, start_tick, bit_tick, stop_tick, push, frame_err;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [NW-1:0]   count;
  logic            pop, full, wr_en, overflow_set;

  // Two-flop synchroniser; only rx_s is used past this point.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rx_meta <= 1'b0;
      rx_s    <= 1'b0;
    end else begin
      rx_meta <= UartRxWire;
      rx_s    <= rx_meta;
    end
  end

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= WAIT_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      WAIT_IDLE: if (rx_s) state_next = IDLE;
      IDLE:      if (!rx_s) state_next = START;
      // A start bit that is high again at mid-bit was a glitch.
      START:     if (start_tick) state_next = rx_s ? IDLE : DATA;
      DATA:      if (bit_tick && bit_idx == 3'd7) state_next = STOP;
      // A low stop bit may be a break; wait for the line to idle first.
      STOP:      if (stop_tick) state_next = rx_s ? IDLE : WAIT_IDLE;
      default:   state_next = WAIT_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    start_tick = (state == START) && (cnt == HALF_LAST);
    bit_tick   = (state == DATA)  && (cnt == BIT_LAST);
    stop_tick  = (state == STOP)  && (cnt == BIT_LAST);
    push       = stop_tick && rx_s;
    frame_err  = stop_tick && !rx_s;
    cnt_clr    = (state == WAIT_IDLE) || (state == IDLE) ||
                 start_tick || bit_tick || stop_tick;
  end

  // Bit-timing counter and LSB-first shift register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CW'(1);
      if (state != DATA) begin
        bit_idx <= 3'd0;
      end else if (bit_tick) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // FIFO control: a push into a full FIFO still succeeds when a pop frees
  // the head slot in the same cycle.
  always_comb begin
    pop          = Valid && Ready;
    full         = (count == FULL_CNT);
    wr_en        = push && (!full || pop);
    overflow_set = push && full && !pop;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'd0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      FrameError <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
      FrameError <= frame_err;
      Overflow   <= overflow_set;
    end
  end

  assign Data  = mem[rd_ptr];
  assign Valid = (count != '0);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, fe, ov;

  int total = 0;
  int bad = 0;
  logic [7:0] got_q[$];
  int fe_cnt = 0;
  int ov_cnt = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .Clk(clk), .Reset(rst), .UartRxWire(rxd), .Data(data), .Valid(valid),
    .Ready(ready), .FrameError(fe), .Overflow(ov)
  );

  // Passive monitor: records every accepted byte and flag-high cycles.
  always @(negedge clk) begin
    if (valid && ready) got_q.push_back(data);
    if (fe) fe_cnt++;
    if (ov) ov_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    fe_cnt = 0;
    ov_cnt = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cycles(CPB);
    end
    rxd = stop;
    wait_cycles(CPB);
  endtask

  task automatic check_got(input string name, input logic [7:0] exp[$]);
    chk({name, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), got_q[i], exp[i]);
  endtask

  task automatic drain_check(input string name, input logic [7:0] exp[$]);
    ready = 1'b1;
    for (int i = 0; i < exp.size(); i++) begin
      @(negedge clk);
      chk($sformatf("%s_valid%0d", name, i), valid, 1'b1);
      chk($sformatf("%s_data%0d", name, i), data, exp[i]);
    end
    @(negedge clk);
    chk({name, "_valid_after"}, valid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         exp_n;
    int         exp_fe;
  } vec_t;

  initial begin
    vec_t vt[6];
    logic [7:0] e[$];
    int n;
    bit done;
    int nbad;
    logic [7:0] rb;
    logic rs;

    vt[0] = '{8'h00, 1'b1, 1, 0};
    vt[1] = '{8'hFF, 1'b1, 1, 0};
    vt[2] = '{8'h5A, 1'b1, 1, 0};
    vt[3] = '{8'h80, 1'b0, 0, 1};
    vt[4] = '{8'h01, 1'b1, 1, 0};
    vt[5] = '{8'hC3, 1'b0, 0, 1};

    // Reset state
    wait_cycles(3);
    chk("rst_valid", valid, 1'b0);
    chk("rst_data", data, 8'h00);
    chk("rst_fe", fe, 1'b0);
    chk("rst_ov", ov, 1'b0);
    rst = 1'b0;
    wait_cycles(10);

    // Scenario 1: exact latency of the first byte
    clear_mon();
    ready = 1'b1;
    n = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (n < 300) begin
          @(posedge clk);
          #1;
          n++;
          if (valid) break;
        end
      end
    join
    chk("s1_latency", n, 155);
    wait_cycles(10);
    e = {}; e.push_back(8'hA5);
    check_got("s1", e);
    chk("s1_fe", fe_cnt, 0);
    chk("s1_ov", ov_cnt, 0);

    // Table of single frames
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      send_frame(vt[i].b, vt[i].stop);
      if (!vt[i].stop) begin
        wait_cycles(2 * CPB);
        rxd = 1'b1;
        wait_cycles(3 * CPB);
      end else begin
        wait_cycles(20);
      end
      chk($sformatf("vec%0d_n", i), got_q.size(), vt[i].exp_n);
      if (vt[i].exp_n == 1 && got_q.size() == 1)
        chk($sformatf("vec%0d_byte", i), got_q[0], vt[i].b);
      chk($sformatf("vec%0d_fe", i), fe_cnt, vt[i].exp_fe);
      chk($sformatf("vec%0d_ov", i), ov_cnt, 0);
    end

    // Scenario 2: short glitch in IDLE
    clear_mon();
    rxd = 1'b0;
    wait_cycles(3);
    rxd = 1'b1;
    wait_cycles(30);
    chk("s2_glitch_none", got_q.size(), 0);
    send_frame(8'h3C, 1'b1);
    wait_cycles(20);
    e = {}; e.push_back(8'h3C);
    check_got("s2", e);
    chk("s2_fe", fe_cnt, 0);
    chk("s2_ov", ov_cnt, 0);

    // Scenario 3: frame error followed by a long break
    clear_mon();
    send_frame(8'h55, 1'b0);
    wait_cycles(40 * CPB);
    chk("s3_fe", fe_cnt, 1);
    chk("s3_none", got_q.size(), 0);
    rxd = 1'b1;
    wait_cycles(30);
    send_frame(8'h81, 1'b1);
    wait_cycles(20);
    e = {}; e.push_back(8'h81);
    check_got("s3", e);
    chk("s3_fe_after", fe_cnt, 1);

    // Scenario 4: overflow on the fifth byte
    ready = 1'b0;
    clear_mon();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    wait_cycles(20);
    chk("s4_ov", ov_cnt, 1);
    chk("s4_fe", fe_cnt, 0);
    e = {};
    for (int i = 1; i <= 4; i++) e.push_back(8'(i));
    drain_check("s4", e);

    // Scenario 5: push and pop together while full
    ready = 1'b0;
    wait_cycles(5);
    clear_mon();
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
    fork
      send_frame(8'h14, 1'b1);
      begin
        wait_cycles(154);
        ready = 1'b1;
        wait_cycles(1);
        ready = 1'b0;
      end
    join
    wait_cycles(20);
    chk("s5_ov", ov_cnt, 0);
    e = {}; e.push_back(8'h10);
    check_got("s5_pop", e);
    e = {};
    for (int i = 1; i <= 4; i++) e.push_back(8'h10 + 8'(i));
    drain_check("s5", e);

    // Scenario 6: reset mid-frame with a stuck-low line afterwards
    ready = 1'b0;
    clear_mon();
    send_frame(8'h22, 1'b1);
    wait_cycles(10);
    chk("s6_hold", valid, 1'b1);
    rb = 8'hF0;
    rxd = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = rb[i];
      wait_cycles(CPB);
    end
    rxd = rb[4];
    wait_cycles(CPB / 2);
    rst = 1'b1;
    rxd = 1'b0;
    @(negedge clk);
    chk("s6_rst_valid", valid, 1'b0);
    chk("s6_rst_data", data, 8'h00);
    chk("s6_rst_fe", fe, 1'b0);
    chk("s6_rst_ov", ov, 1'b0);
    wait_cycles(3);
    rst = 1'b0;
    clear_mon();
    ready = 1'b1;
    wait_cycles(200);
    chk("s6_low_none", got_q.size(), 0);
    chk("s6_low_fe", fe_cnt, 0);
    rxd = 1'b1;
    wait_cycles(20);
    send_frame(8'h99, 1'b1);
    wait_cycles(20);
    e = {}; e.push_back(8'h99);
    check_got("s6", e);
    chk("s6_ov", ov_cnt, 0);

    // Randomized frames against an in-order byte model
    clear_mon();
    e = {};
    nbad = 0;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          rb = 8'($urandom_range(0, 255));
          rs = ($urandom_range(0, 7) != 0);
          send_frame(rb, rs);
          if (rs) begin
            e.push_back(rb);
          end else begin
            nbad++;
            wait_cycles($urandom_range(CPB, 4 * CPB));
            rxd = 1'b1;
            wait_cycles(24);
          end
          wait_cycles($urandom_range(0, 20));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          ready = 1'($urandom_range(0, 1));
        end
      end
    join
    ready = 1'b1;
    wait_cycles(40);
    check_got("rand", e);
    chk("rand_fe", fe_cnt, nbad);
    chk("rand_ov", ov_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
